// File: rtl/ebpc_symbol_packer.sv
// ebpc_symbol_packer
//   Packs variable-length EBPC symbols (2..MAX_SYMB_LEN bits, MSB first) into
//   OUT_W-bit words. The first bit of a transfer lands at data_o[OUT_W-1].
//   When a transfer ends (last_i), the packer drains its remaining bits as
//   one or more words. The final word is flagged with last_o, and nbits_o
//   gives its number of meaningful, MSB-aligned bits.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   symb_i              right-aligned symbol; bits above the decoded length are ignored
//   len_i               ebpc_pkg::symb_len_t length code
//   last_i              final symbol of the transfer
//   in_valid_i/in_ready_o    upstream handshake
//   data_o, nbits_o, last_o  packed word, meaningful bit count, final-word flag
//   out_valid_o/out_ready_i  downstream handshake
//   state_o             debug: 0 = ACCEPT, 1 = FLUSH
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds valid and its payload steady until the transfer
// happens. in_ready_o may depend combinationally on out_ready_i.

package ebpc_pkg;
   localparam int unsigned LOG_DATA_W   = 3;
   localparam int unsigned BLOCK_SIZE   = 8;
   localparam int unsigned MAX_SYMB_LEN = 8;
   typedef enum logic [2:0] {
      TWO             = 3'd0,
      THREE_PLUS_LOGM = 3'd1,
      FIVE            = 3'd2,
      FIVE_PLUS_LOGN  = 3'd3,
      N               = 3'd4
   } symb_len_t;
endpackage

module ebpc_symbol_packer #(
   parameter int unsigned OUT_W = 32
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [ebpc_pkg::MAX_SYMB_LEN-1:0] symb_i,
   input  logic [2:0]                        len_i,
   input  logic                              last_i,
   input  logic                              in_valid_i,
   output logic                              in_ready_o,
   output logic [OUT_W-1:0]                  data_o,
   output logic [$clog2(OUT_W+1)-1:0]        nbits_o,
   output logic                              last_o,
   output logic                              out_valid_o,
   input  logic                              out_ready_i,
   output logic                              state_o
);

   localparam int unsigned MAX_L = ebpc_pkg::MAX_SYMB_LEN;
   localparam int unsigned BUF_W = OUT_W + MAX_L;
   localparam int unsigned CNT_W = $clog2(BUF_W);
   localparam int unsigned NB_W  = $clog2(OUT_W + 1);
   localparam int unsigned LEN_W = $clog2(MAX_L + 1);
   localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);

   generate
      if (OUT_W < MAX_L) begin : g_bad_out_w
         $error("ebpc_symbol_packer: OUT_W must be >= MAX_SYMB_LEN");
      end
   endgenerate

   typedef enum logic {ACCEPT = 1'b0, FLUSH = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [BUF_W-1:0]  buf_q, buf_d;   // oldest bit at buf_q[BUF_W-1]; bits below the fill level are always zero
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic [LEN_W-1:0]  len;
   logic [BUF_W-1:0]  sym_top;        // symbol moved to the top of a buffer-wide vector
   logic [BUF_W-1:0]  base_buf;
   logic [CNT_W-1:0]  base_cnt;
   logic              push, pop;

   // Length decode; unknown codes consume the symbol but add no bits.
   always_comb begin
      len = '0;
      case (len_i)
         3'd0:    len = LEN_W'(2);
         3'd1:    len = LEN_W'(3 + ebpc_pkg::LOG_DATA_W);
         3'd2:    len = LEN_W'(5);
         3'd3:    len = LEN_W'(5 + $clog2(ebpc_pkg::BLOCK_SIZE));
         3'd4:    len = LEN_W'(ebpc_pkg::BLOCK_SIZE);
         default: len = '0;
      endcase
   end

   // Outputs and handshake decisions
   always_comb begin
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      nbits_o     = '0;
      last_o      = 1'b0;
      data_o      = buf_q[BUF_W-1 -: OUT_W];
      if (state_q == ACCEPT) begin
         out_valid_o = (cnt_q >= OUT_W_C);
         in_ready_o  = (cnt_q < OUT_W_C) || out_ready_i;
         nbits_o     = out_valid_o ? NB_W'(OUT_W) : '0;
      end else begin
         out_valid_o = (cnt_q != '0);
         nbits_o     = (cnt_q >= OUT_W_C) ? NB_W'(OUT_W) : NB_W'(cnt_q);
         last_o      = out_valid_o && (cnt_q <= OUT_W_C);
      end
   end

   assign push    = in_valid_i && in_ready_o;
   assign pop     = out_valid_o && out_ready_i;
   assign state_o = state_q;

   // Shifting the symbol up by (MAX_L - len) pushes the ignored upper bits
   // out of the vector, so no explicit mask is needed.
   assign sym_top = {symb_i, {OUT_W{1'b0}}} << (LEN_W'(MAX_L) - len);

   // Pop first, then append the new symbol directly behind the bits that remain.
   always_comb begin
      base_buf = buf_q;
      base_cnt = cnt_q;
      state_d  = state_q;
      if (pop) begin
         if (last_o) begin
            base_buf = '0;
            base_cnt = '0;
         end else begin
            base_buf = buf_q << OUT_W;
            base_cnt = cnt_q - OUT_W_C;
         end
      end
      buf_d = base_buf;
      cnt_d = base_cnt;
      if (push) begin
         buf_d = base_buf | (sym_top >> base_cnt);
         cnt_d = base_cnt + CNT_W'(len);
      end
      case (state_q)
         ACCEPT:  if (push && last_i) state_d = FLUSH;
         // An empty FLUSH (transfer of zero-length symbols) has nothing to emit.
         FLUSH:   if ((pop && last_o) || (cnt_q == '0)) state_d = ACCEPT;
         default: state_d = ACCEPT;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ACCEPT;
         buf_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
      end
   end

   a_len_code : assert property (@(posedge clk_i) disable iff (rst_i)
      (in_valid_i && in_ready_o) |-> (len_i <= 3'd4));

endmodule

// File: tb/tb_ebpc_symbol_packer.sv
// Bench for ebpc_symbol_packer: directed transfers plus randomized traffic,
// checked against a bit-queue reference model of the packing rules.
module tb_ebpc_symbol_packer;

  localparam int OUT_W = 32;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  symb_i = '0;
  logic [2:0]  len_i = '0;
  logic        last_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] data_o;
  logic [5:0]  nbits_o;
  logic        last_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic        state_o;

  ebpc_symbol_packer #(.OUT_W(OUT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .symb_i(symb_i), .len_i(len_i),
    .last_i(last_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .data_o(data_o), .nbits_o(nbits_o), .last_o(last_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit q[$];          // bits of the current transfer not yet emitted, oldest first
  bit closed = 0;    // last symbol of the transfer has been accepted
  logic [31:0] exp_q[$];
  logic [31:0] obs_data[$];
  logic [31:0] obs_nbits[$];
  logic [31:0] obs_last[$];

  function automatic int decode_len(input logic [2:0] code);
    case (code)
      3'd0: return 2;
      3'd1: return 3 + ebpc_pkg::LOG_DATA_W;
      3'd2: return 5;
      3'd3: return 5 + $clog2(ebpc_pkg::BLOCK_SIZE);
      3'd4: return ebpc_pkg::BLOCK_SIZE;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk_i) begin
    if (rst_i) begin
      q.delete();
      closed = 0;
    end else begin
      logic exp_ov, exp_ir, exp_last;
      int n;
      logic [31:0] w;
      exp_ov = (q.size() >= OUT_W) || (closed && q.size() > 0);
      exp_ir = !closed && ((q.size() < OUT_W) || (exp_ov && out_ready_i));
      check("out_valid", {31'b0, out_valid_o}, {31'b0, exp_ov});
      check("in_ready", {31'b0, in_ready_o}, {31'b0, exp_ir});
      if (out_valid_o && out_ready_i) begin
        n = (closed && q.size() < OUT_W) ? q.size() : OUT_W;
        w = '0;
        for (int i = 0; i < n; i++) if (i < q.size()) w[31-i] = q[i];
        exp_last = closed && (q.size() <= OUT_W);
        check("data", data_o, w);
        check("nbits", {26'b0, nbits_o}, n);
        check("last", {31'b0, last_o}, {31'b0, exp_last});
        for (int i = 0; i < n; i++) if (q.size() > 0) void'(q.pop_front());
        if (exp_last) closed = 0;
        obs_data.push_back(data_o);
        obs_nbits.push_back({26'b0, nbits_o});
        obs_last.push_back({31'b0, last_o});
      end
      if (in_valid_i && in_ready_o) begin
        for (int i = decode_len(len_i) - 1; i >= 0; i--) q.push_back(symb_i[i]);
        if (last_i) closed = 1;
      end
    end
  end

  // out_ready_i pattern: 0 = always 1, 1 = always 0, 2 = random
  int rmode = 0;
  always @(posedge clk_i) begin
    #1;
    case (rmode)
      0: out_ready_i = 1'b1;
      1: out_ready_i = 1'b0;
      default: out_ready_i = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the symbol is accepted.
  task automatic send(input logic [7:0] s, input logic [2:0] l, input logic lst);
    logic fire;
    int n = 0;
    symb_i = s; len_i = l; last_i = lst; in_valid_i = 1'b1;
    do begin
      @(negedge clk_i); fire = in_ready_o;
      @(posedge clk_i); #1;
      n++;
    end while (!fire && n < 300);
    if (!fire) check("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int k);
    in_valid_i = 1'b0; last_i = 1'b0;
    repeat (k) begin @(posedge clk_i); #1; end
  endtask

  task automatic wait_drain();
    int n = 0;
    bit done = 0;
    while (!done && n < 500) begin
      @(negedge clk_i);
      done = (q.size() == 0) && !closed && !out_valid_o;
      n++;
    end
    @(posedge clk_i); #1;
    if (!done) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic obs_clear();
    obs_data.delete(); obs_nbits.delete(); obs_last.delete();
  endtask

  task automatic check_word(input string tag, input int idx, input logic [31:0] d,
                            input logic [31:0] nb, input logic [31:0] lst);
    check({tag, "_count"}, (obs_data.size() > idx) ? 32'd1 : 32'd0, 32'd1);
    if (obs_data.size() > idx) begin
      check({tag, "_data"}, obs_data[idx], d);
      check({tag, "_nbits"}, obs_nbits[idx], nb);
      check({tag, "_last"}, obs_last[idx], lst);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1;
    check("rst_in_ready", {31'b0, in_ready_o}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_nbits", {26'b0, nbits_o}, 32'd0);
    check("rst_last", {31'b0, last_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Four 8-bit symbols into exactly one word
    rmode = 0; obs_clear();
    send(8'hA5, 3'd3, 0); send(8'h3C, 3'd3, 0); send(8'hFF, 3'd3, 0); send(8'h01, 3'd3, 1);
    idle(0); wait_drain();
    check("t27_words", obs_data.size(), 32'd1);
    check_word("t27", 0, 32'hA53CFF01, 32'd32, 32'd1);

    // Mixed lengths, upper symbol bits ignored
    obs_clear();
    send(8'hFF, 3'd0, 0); send(8'hF5, 3'd2, 0); send(8'hC1, 3'd1, 1);
    idle(0); wait_drain();
    check_word("t28", 0, 32'hEA080000, 32'd13, 32'd1);

    // Five N symbols back to back
    obs_clear();
    for (int i = 1; i <= 5; i++) send(8'(i * 8'h11), 3'd4, i == 5);
    idle(0); wait_drain();
    check_word("t29a", 0, 32'h11223344, 32'd32, 32'd0);
    check_word("t29b", 1, 32'h55000000, 32'd8, 32'd1);

    // Backpressure: input stalls once a full word is waiting
    rmode = 1; obs_clear();
    for (int i = 1; i <= 4; i++) send(8'(i), 3'd4, 0);
    symb_i = 8'h05; len_i = 3'd4; last_i = 1'b1; in_valid_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      check("t30_stall_ready", {31'b0, in_ready_o}, 32'd0);
      check("t30_stall_data", data_o, 32'h01020304);
    end
    @(posedge clk_i); #1;
    rmode = 0;
    send(8'h05, 3'd4, 1); idle(0); wait_drain();
    check_word("t30a", 0, 32'h01020304, 32'd32, 32'd0);
    check_word("t30b", 1, 32'h05000000, 32'd8, 32'd1);

    // Single short symbol held under backpressure
    rmode = 1; obs_clear();
    send(8'h02, 3'd0, 1); idle(0);
    repeat (5) begin
      @(negedge clk_i);
      check("t31_valid", {31'b0, out_valid_o}, 32'd1);
      check("t31_data", data_o, 32'h80000000);
      check("t31_nbits", {26'b0, nbits_o}, 32'd2);
      check("t31_ready", {31'b0, in_ready_o}, 32'd0);
    end
    @(posedge clk_i); #1;
    rmode = 0; wait_drain();
    @(negedge clk_i);
    check("t31_ready_after", {31'b0, in_ready_o}, 32'd1);
    @(posedge clk_i); #1;

    // Reset in the middle of a flush with 20 bits pending
    rmode = 1; obs_clear();
    send(8'h12, 3'd4, 0); send(8'h34, 3'd4, 0); send(8'h03, 3'd0, 0); send(8'h01, 3'd0, 1);
    idle(1);
    #2 rst_i = 1'b1;
    #1;
    check("t32_flush_pre", {31'b0, out_valid_o}, 32'd0);
    check("t32_rst_data", data_o, 32'd0);
    check("t32_rst_nbits", {26'b0, nbits_o}, 32'd0);
    check("t32_rst_last", {31'b0, last_o}, 32'd0);
    check("t32_rst_ready", {31'b0, in_ready_o}, 32'd1);
    @(posedge clk_i); #1 rst_i = 1'b0;
    rmode = 0; obs_clear();
    send(8'h01, 3'd0, 1); idle(0); wait_drain();
    check_word("t32", 0, 32'h40000000, 32'd2, 32'd1);

    // Randomized transfers with random backpressure and input gaps
    rmode = 2;
    for (int t = 0; t < 25; t++) begin
      int ns;
      ns = $urandom_range(1, 14);
      for (int k = 0; k < ns; k++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        send(8'($urandom), 3'($urandom_range(0, 4)), k == ns - 1);
      end
      idle(0);
    end
    rmode = 0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ebpc_symbol_packer.md
EBPC_SYMBOL_PACKER -- requirements
Module: ebpc_symbol_packer

Interface
REQ-001: OUT_W, 32, packed output word width; SHALL be >= ebpc_pkg::MAX_SYMB_LEN, elaboration error otherwise.
REQ-002: clk_i  input  1  sole clock; all state on rising edge.
REQ-003: rst_i  input  1  reset, asynchronous, active-high.
REQ-004: symb_i  input  MAX_SYMB_LEN  encoded symbol, right-aligned; bits above decoded length ignored.
REQ-005: len_i  input  3  ebpc_pkg::symb_len_t code: TWO=0, THREE_PLUS_LOGM=1, FIVE=2, FIVE_PLUS_LOGN=3, N=4.
REQ-006: last_i  input  1  marks final symbol of a transfer.
REQ-007: in_valid_i / in_ready_o  input / output  1 / 1  upstream valid/ready handshake.
REQ-008: data_o  output  OUT_W  packed word; first bit of the stream at bit OUT_W-1.
REQ-009: nbits_o  output  $clog2(OUT_W+1)  count of meaningful bits in data_o, MSB-aligned.
REQ-010: last_o  output  1  data_o is the final word of the transfer.
REQ-011: out_valid_o / out_ready_i  output / input  1 / 1  downstream valid/ready handshake.

Function
REQ-012: Length decode SHALL be TWO->2, THREE_PLUS_LOGM->3+LOG_DATA_W, FIVE->5, FIVE_PLUS_LOGN->5+$clog2(BLOCK_SIZE), N->BLOCK_SIZE; codes 5-7 SHALL decode to 0 bits (symbol consumed, nothing appended) and trigger a simulation assertion.
REQ-013: Symbol bits SHALL be appended MSB-first: symb_i[L-1] enters the stream first.
REQ-014: Block SHALL hold a bit buffer of OUT_W+MAX_SYMB_LEN bits and a fill counter cnt (0..OUT_W+MAX_SYMB_LEN-1).
REQ-015: FSM states: ACCEPT and FLUSH; reset state ACCEPT.
REQ-016: In ACCEPT, out_valid_o SHALL be 1 iff cnt >= OUT_W; data_o = oldest OUT_W bits, nbits_o = OUT_W, last_o = 0.
REQ-017: In ACCEPT, in_ready_o SHALL be (cnt < OUT_W) OR (out_valid_o AND out_ready_i); combinational path out_ready_i->in_ready_o is permitted.
REQ-018: Output handshake SHALL remove OUT_W bits (cnt -= OUT_W); input handshake SHALL add L bits; both in one cycle SHALL apply both, remaining bits contiguous and order-preserving.
REQ-019: Input handshake with last_i=1 SHALL move FSM to FLUSH in the next cycle.
REQ-020: In FLUSH, in_ready_o SHALL be 0; out_valid_o SHALL be 1 iff cnt > 0; nbits_o = min(cnt, OUT_W); last_o = 1 iff cnt <= OUT_W; bits beyond nbits_o SHALL be zero.
REQ-021: Output handshake with last_o=1 SHALL set cnt = 0 and return to ACCEPT; no words emitted with nbits_o = 0.
REQ-022: Throughput: one symbol per cycle sustained while out_ready_i=1; no bubbles from word emission.
REQ-023: data_o, nbits_o, last_o SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-024: Bits SHALL never be dropped or duplicated; total emitted nbits_o per transfer equals sum of decoded lengths.

Reset
REQ-025: Asserting rst_i at any time, including mid-FLUSH, SHALL asynchronously clear cnt, buffer and FSM (ACCEPT); outputs during/after reset: in_ready_o=1, out_valid_o=0, data_o=0, nbits_o=0, last_o=0.
REQ-026: Partial-word content at reset SHALL be discarded; first transfer after reset starts at bit OUT_W-1.

Verification
REQ-027: Four FIVE_PLUS_LOGN symbols 0xA5,0x3C,0xFF,0x01 (last on 4th), out_ready_i=1 -> one word 0xA53CFF01, nbits_o=32, last_o=1.
REQ-028: TWO 2'b11, FIVE 5'b10101, THREE_PLUS_LOGM 6'b000001 (last) -> data_o=0xEA080000, nbits_o=13, last_o=1.
REQ-029: Five N symbols 0x11..0x55 (last on 5th), back-to-back -> 0x11223344/nbits 32/last 0, then 0x55000000/nbits 8/last 1; in_ready_o never drops before last.
REQ-030: out_ready_i=0 throughout, 8-bit symbols streamed -> in_ready_o falls after 4th symbol (cnt=32), data_o stable; releasing out_ready_i resumes with zero lost bits.
REQ-031: Single TWO 2'b10 with last_i, out_ready_i=0 for 5 cycles -> out_valid_o held with 0x80000000, nbits_o=2, last_o=1; in_ready_o=0 until accepted, then 1.
REQ-032: rst_i pulsed while in FLUSH with cnt=20 -> outputs zero immediately, next transfer TWO 2'b01 last -> 0x40000000, nbits_o=2.
